cordic_arbiter: RTL



---
 rtl/cordic_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter that sequences N_REQ requesters onto one shared CORDIC core.
// One operation in flight; the result goes back to its requester with a one-cycle strobe.
module cordic_arbiter #(
  parameter int WIDTH   = 32,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [4*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_x,
  input  logic [WIDTH*N_REQ-1:0] req_y,
  input  logic [WIDTH*N_REQ-1:0] req_z,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   core_enable,
  output logic [3:0]             core_operation,
  output logic [WIDTH-1:0]       core_x,
  output logic [WIDTH-1:0]       core_y,
  output logic [WIDTH-1:0]       core_z,
  input  logic [WIDTH-1:0]       core_result,
  input  logic                   core_done
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, idx_q, idx_d, sel;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, res_q, res_d;
  logic             err_q, err_d, found;
  logic [N_REQ-1:0] gnt_q, gnt_d;

  // First set request bit at or above ptr, wrapping around.
  always_comb begin : sel_p
    int j;
    j     = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    res_d   = res_q;
    err_d   = err_q;
    gnt_d   = '0;
    case (state_q)
      IDLE: if (found) begin
        idx_d      = sel;
        op_d       = req_op[4*int'(sel) +: 4];
        x_d        = req_x[WIDTH*int'(sel) +: WIDTH];
        y_d        = req_y[WIDTH*int'(sel) +: WIDTH];
        z_d        = req_z[WIDTH*int'(sel) +: WIDTH];
        gnt_d[sel] = 1'b1;
        if (req_op[4*int'(sel) +: 4] <= 4'd9) begin
          state_d = ISSUE;
        end else begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // cnt_q==0 is the first WAIT cycle, where done may still be stale.
        if (cnt_q != '0 && core_done) begin
          res_d   = core_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (idx_q == IW'(N_REQ-1)) ? '0 : idx_q + IW'(1);
        op_d    = 4'b1111;
        x_d     = '0;
        y_d     = '0;
        z_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      op_q    <= 4'b1111;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      res_q   <= res_d;
      err_q   <= err_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      rsp_valid[i] = (state_q == RESP) && (idx_q == IW'(i));
  end

  assign gnt            = gnt_q;
  assign rsp_result     = (state_q == RESP) ? res_q : '0;
  assign rsp_error      = (state_q == RESP) && err_q;
  assign busy           = (state_q != IDLE);
  assign core_enable    = (state_q == ISSUE);
  assign core_operation = op_q;
  assign core_x         = x_q;
  assign core_y         = y_q;
  assign core_z         = z_q;
endmodule
